// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, memory-stage state type and access helpers
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_STOP = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_t;

    // Faulted or illegal records never touch memory, whatever their icode.
    function automatic acc_kind_t classify(input logic [3:0] icode,
                                           input logic       instr_valid,
                                           input logic       imem_error);
        acc_kind_t kind;
        kind = ACC_NONE;
        if (instr_valid && !imem_error) begin
            case (icode)
                IMRMOVQ, IPOPQ, IRET:   kind = ACC_READ;
                IRMMOVQ, IPUSHQ, ICALL: kind = ACC_WRITE;
                default:                kind = ACC_NONE;
            endcase
        end
        return kind;
    endfunction

    function automatic logic [63:0] access_addr(input logic [3:0]  icode,
                                                input logic [63:0] val_e,
                                                input logic [63:0] val_a);
        return (icode == IPOPQ || icode == IRET) ? val_a : val_e;
    endfunction

    function automatic logic [63:0] access_wdata(input logic [3:0]  icode,
                                                 input logic [63:0] val_a,
                                                 input logic [63:0] val_p);
        return (icode == ICALL) ? val_p : val_a;
    endfunction

    // Written as addr <= bytes-8 so that addr+8 can never wrap.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] bytes);
        return (bytes >= 64'd8) && (addr <= bytes - 64'd8);
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - data-memory request/acknowledge port of the memory stage
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic        dmem_ack;
    logic        dmem_err;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/memory_access.sv
// rtl/memory_access.sv - Y86-64 memory stage: one record per handshake, variable-latency data port
module memory_access
    import y86_pkg::*;
#(
    parameter logic [63:0] DMEM_BYTES = 64'd65536,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    input  logic        instr_valid_i,
    input  logic        imem_error_i,
    memory_access_if.master dmem,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [3:0]  icode_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic        instr_valid_o,
    output logic        imem_error_o,
    output logic        dmem_error_o,
    output logic        halted_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [3:0]  icode_q, icode_d;
    logic [63:0] val_e_q, val_e_d;
    logic [63:0] val_m_q, val_m_d;
    logic [3:0]  dst_e_q, dst_e_d;
    logic [3:0]  dst_m_q, dst_m_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_error_q, imem_error_d;
    logic        dmem_error_q, dmem_error_d;
    logic        halted_q, halted_d;
    logic        we_q, we_d;
    logic        is_read_q, is_read_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;

    acc_kind_t   acc;
    logic [63:0] in_addr;
    logic        in_range;
    logic        take;
    logic        stop_cond;

    assign ready_o = !halted_q && (state_q == S_IDLE || (state_q == S_DONE && ready_i));
    assign valid_o = (state_q == S_DONE);

    // Request is derived from state so the asynchronous reset drops it at once.
    assign dmem.dmem_req   = (state_q == S_WAIT);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign icode_o       = icode_q;
    assign valE_o        = val_e_q;
    assign valM_o        = val_m_q;
    assign dstE_o        = dst_e_q;
    assign dstM_o        = dst_m_q;
    assign instr_valid_o = instr_valid_q;
    assign imem_error_o  = imem_error_q;
    assign dmem_error_o  = dmem_error_q;
    assign halted_o      = halted_q;

    assign stop_cond = (icode_q == IHALT) || !instr_valid_q || imem_error_q || dmem_error_q;

    always_comb begin
        state_d       = state_q;
        icode_d       = icode_q;
        val_e_d       = val_e_q;
        val_m_d       = val_m_q;
        dst_e_d       = dst_e_q;
        dst_m_d       = dst_m_q;
        instr_valid_d = instr_valid_q;
        imem_error_d  = imem_error_q;
        dmem_error_d  = dmem_error_q;
        halted_d      = halted_q;
        we_d          = we_q;
        is_read_d     = is_read_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        take          = 1'b0;

        acc      = classify(icode_i, instr_valid_i, imem_error_i);
        in_addr  = access_addr(icode_i, valE_i, valA_i);
        in_range = addr_in_range(in_addr, DMEM_BYTES);

        case (state_q)
            S_IDLE: take = valid_i && !halted_q;
            S_WAIT: begin
                if (dmem.dmem_ack) begin
                    val_m_d      = is_read_q ? dmem.dmem_rdata : 64'd0;
                    dmem_error_d = dmem.dmem_err;
                    state_d      = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    val_m_d      = 64'd0;
                    dmem_error_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    // Records offered alongside a stopping retire are dropped.
                    if (stop_cond) begin
                        state_d  = S_STOP;
                        halted_d = 1'b1;
                    end else if (valid_i) begin
                        take = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_STOP;
        endcase

        if (take) begin
            icode_d       = icode_i;
            val_e_d       = valE_i;
            dst_e_d       = dstE_i;
            dst_m_d       = dstM_i;
            instr_valid_d = instr_valid_i;
            imem_error_d  = imem_error_i;
            val_m_d       = 64'd0;
            if (acc != ACC_NONE && in_range) begin
                addr_d       = in_addr;
                wdata_d      = access_wdata(icode_i, valA_i, valP_i);
                we_d         = (acc == ACC_WRITE);
                is_read_d    = (acc == ACC_READ);
                cnt_d        = 8'd0;
                dmem_error_d = 1'b0;
                state_d      = S_WAIT;
            end else begin
                dmem_error_d = (acc != ACC_NONE);
                state_d      = S_DONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            icode_q       <= 4'h0;
            val_e_q       <= 64'd0;
            val_m_q       <= 64'd0;
            dst_e_q       <= RNONE;
            dst_m_q       <= RNONE;
            instr_valid_q <= 1'b0;
            imem_error_q  <= 1'b0;
            dmem_error_q  <= 1'b0;
            halted_q      <= 1'b0;
            we_q          <= 1'b0;
            is_read_q     <= 1'b0;
            addr_q        <= 64'd0;
            wdata_q       <= 64'd0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            icode_q       <= icode_d;
            val_e_q       <= val_e_d;
            val_m_q       <= val_m_d;
            dst_e_q       <= dst_e_d;
            dst_m_q       <= dst_m_d;
            instr_valid_q <= instr_valid_d;
            imem_error_q  <= imem_error_d;
            dmem_error_q  <= dmem_error_d;
            halted_q      <= halted_d;
            we_q          <= we_d;
            is_read_q     <= is_read_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, ready_i, valid_o;
    logic [3:0]  icode_i, dstE_i, dstM_i;
    logic [63:0] valE_i, valA_i, valP_i;
    logic        instr_valid_i, imem_error_i;
    logic [3:0]  icode_o, dstE_o, dstM_o;
    logic [63:0] valE_o, valM_o;
    logic        instr_valid_o, imem_error_o, dmem_error_o, halted_o;

    int tests_run = 0;
    int tests_failed = 0;

    memory_access_if dmem ();

    memory_access #(.DMEM_BYTES(64'd65536), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .icode_i(icode_i), .valE_i(valE_i), .valA_i(valA_i), .valP_i(valP_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i),
        .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i),
        .dmem(dmem.master),
        .valid_o(valid_o), .ready_i(ready_i),
        .icode_o(icode_o), .valE_o(valE_o), .valM_o(valM_o),
        .dstE_o(dstE_o), .dstM_o(dstM_o),
        .instr_valid_o(instr_valid_o), .imem_error_o(imem_error_o),
        .dmem_error_o(dmem_error_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p, input logic [3:0] de, input logic [3:0] dm);
        valid_i = 1'b1; icode_i = ic; valE_i = e; valA_i = a; valP_i = p;
        dstE_i = de; dstM_i = dm; instr_valid_i = 1'b1; imem_error_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; valid_i = 0; ready_i = 0; icode_i = 0; valE_i = 0; valA_i = 0; valP_i = 0;
        dstE_i = 4'hF; dstM_i = 4'hF; instr_valid_i = 1; imem_error_i = 0;
        dmem.dmem_ack = 0; dmem.dmem_err = 0; dmem.dmem_rdata = 0;
        #2;
        do_reset();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_req", dmem.dmem_req, 0);
        check("rst_dstE", dstE_o, 4'hF);
        check("rst_dstM", dstM_o, 4'hF);
        check("rst_valM", valM_o, 0);
        check("rst_halted", halted_o, 0);

        // NOP: valid one cycle after accept, no request
        drive(4'h1, 64'h10, 64'h0, 64'h0, 4'hF, 4'hF);
        tick();
        valid_i = 0;
        check("nop_valid", valid_o, 1);
        check("nop_req", dmem.dmem_req, 0);
        check("nop_valM", valM_o, 0);
        check("nop_valE", valE_o, 64'h10);
        ready_i = 1; tick(); ready_i = 0;
        check("nop_retire", valid_o, 0);
        check("nop_halted", halted_o, 0);

        // MRMOVQ: ack sampled at the third edge after accept
        drive(4'h5, 64'h100, 64'h999, 64'h0, 4'hF, 4'h3);
        tick();
        valid_i = 0;
        check("rd_req", dmem.dmem_req, 1);
        check("rd_addr", dmem.dmem_addr, 64'h100);
        check("rd_we", dmem.dmem_we, 0);
        check("rd_ready_wait", ready_o, 0);
        tick(); tick();
        check("rd_req_hold", dmem.dmem_req, 1);
        check("rd_valid_early", valid_o, 0);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 64'hDEAD_BEEF;
        tick();
        dmem.dmem_ack = 0; dmem.dmem_rdata = 0;
        check("rd_valid", valid_o, 1);
        check("rd_valM", valM_o, 64'hDEAD_BEEF);
        check("rd_req_drop", dmem.dmem_req, 0);
        check("rd_err", dmem_error_o, 0);
        check("rd_dstM", dstM_o, 4'h3);
        ready_i = 1; tick(); ready_i = 0;

        // CALL: write of valP at valE
        drive(4'h8, 64'h1F8, 64'h7, 64'h42, 4'h4, 4'hF);
        tick();
        valid_i = 0;
        check("call_req", dmem.dmem_req, 1);
        check("call_we", dmem.dmem_we, 1);
        check("call_addr", dmem.dmem_addr, 64'h1F8);
        check("call_wdata", dmem.dmem_wdata, 64'h42);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 64'h5555;
        tick();
        dmem.dmem_ack = 0;
        check("call_valid", valid_o, 1);
        check("call_valM", valM_o, 0);
        ready_i = 1; tick(); ready_i = 0;

        // POPQ at last legal address 0xFFF8 uses valA
        drive(4'hB, 64'h8, 64'hFFF8, 64'h0, 4'h4, 4'h2);
        tick();
        valid_i = 0;
        check("pop_req", dmem.dmem_req, 1);
        check("pop_addr", dmem.dmem_addr, 64'hFFF8);
        dmem.dmem_ack = 1; dmem.dmem_rdata = 64'h77;
        tick();
        dmem.dmem_ack = 0;
        check("pop_valM", valM_o, 64'h77);
        check("pop_err", dmem_error_o, 0);
        ready_i = 1; tick(); ready_i = 0;

        // Out of range RMMOVQ, then halt on retire; offered NOP is dropped
        drive(4'h4, 64'hFFF9, 64'h1, 64'h0, 4'hF, 4'hF);
        tick();
        valid_i = 0;
        check("oor_req", dmem.dmem_req, 0);
        check("oor_valid", valid_o, 1);
        check("oor_err", dmem_error_o, 1);
        drive(4'h1, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        ready_i = 1; tick();
        check("oor_halted", halted_o, 1);
        check("oor_ready", ready_o, 0);
        check("oor_valid_after", valid_o, 0);
        tick();
        check("oor_ready_stuck", ready_o, 0);
        check("oor_req_stuck", dmem.dmem_req, 0);
        valid_i = 0; ready_i = 0;

        // Timeout with TIMEOUT=4: four WAIT cycles, then error
        do_reset();
        check("to_unhalted", halted_o, 0);
        drive(4'h5, 64'h200, 64'h0, 64'h0, 4'hF, 4'h1);
        tick();
        valid_i = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_req_hold", dmem.dmem_req, 1);
            if (i < 3) tick();
        end
        tick();
        check("to_req_drop", dmem.dmem_req, 0);
        check("to_valid", valid_o, 1);
        check("to_err", dmem_error_o, 1);
        check("to_valM", valM_o, 0);
        ready_i = 1; tick(); ready_i = 0;
        check("to_halted", halted_o, 1);

        // Reset during WAIT drops the request without a clock edge
        do_reset();
        drive(4'h5, 64'h300, 64'h0, 64'h0, 4'hF, 4'h1);
        tick();
        valid_i = 0;
        check("rw_req", dmem.dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rw_req_async", dmem.dmem_req, 0);
        check("rw_ready", ready_o, 1);
        tick();
        rst = 1'b0;
        dmem.dmem_ack = 1; dmem.dmem_rdata = 64'hABC;
        tick();
        dmem.dmem_ack = 0;
        check("rw_ack_ignored", valid_o, 0);
        check("rw_valM", valM_o, 0);

        // Eight back-to-back OPq records
        ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            drive(4'h6, 64'(i + 1), 64'h0, 64'h0, 4'(i), 4'hF);
            check("bb_ready", ready_o, 1);
            tick();
            check("bb_valid", valid_o, 1);
            check("bb_valE", valE_o, 64'(i + 1));
        end
        valid_i = 0;
        tick();
        check("bb_idle", valid_o, 0);

        // HALT retires and stops
        drive(4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        tick();
        valid_i = 0;
        check("halt_valid", valid_o, 1);
        check("halt_not_yet", halted_o, 0);
        tick();
        check("halt_halted", halted_o, 1);
        ready_i = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
